// File: rtl/exe_issue_stage.sv
// ID/EXE issue stage: holds one decoded instruction, drives the ALU through a
// MEM/WB bypass network and hands the result to MEM. Optional counters: EXE_PERF_CNT_EN.
module exe_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [4:0]    id_alu_control,
  input  logic [DW-1:0] id_src1,
  input  logic [DW-1:0] id_src2,
  input  logic [RW-1:0] id_src1_reg,
  input  logic [RW-1:0] id_src2_reg,
  input  logic [RW-1:0] id_dest,
  input  logic          id_wen,
  input  logic          mem_allow,
  output logic          exe_valid,
  output logic [4:0]    exe_alu_control,
  output logic [DW-1:0] exe_alu_src1,
  output logic [DW-1:0] exe_alu_src2,
  input  logic [DW-1:0] alu_result,
  output logic [DW-1:0] exe_result,
  output logic [RW-1:0] exe_dest,
  output logic          exe_wen,
  input  logic          fwd_mem_wen,
  input  logic [RW-1:0] fwd_mem_dest,
  input  logic [DW-1:0] fwd_mem_data,
  input  logic          fwd_wb_wen,
  input  logic [RW-1:0] fwd_wb_dest,
  input  logic [DW-1:0] fwd_wb_data
`ifdef EXE_PERF_CNT_EN
  ,
  output logic [31:0]   perf_issue_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  // Handshake: ID transfers when id_valid & id_ready; EXE hands off to MEM when
  // exe_valid & mem_allow. id_ready depends only on EXE occupancy and mem_allow.
  logic          valid_q;
  logic [4:0]    op_q;
  logic [DW-1:0] src1_q;
  logic [DW-1:0] src2_q;
  logic [RW-1:0] src1_reg_q;
  logic [RW-1:0] src2_reg_q;
  logic [RW-1:0] dest_q;
  logic          wen_q;

  logic          accept;
  logic          load;
  logic          mem_hit1, wb_hit1, mem_hit2, wb_hit2;
  logic [DW-1:0] src1_byp;
  logic [DW-1:0] src2_byp;

  assign id_ready = ~valid_q | mem_allow;
  assign accept   = id_valid & id_ready;
  assign load     = accept & ~flush;

  // Register 0 is never a bypass target; MEM is younger than WB so it wins.
  always_comb begin
    mem_hit1 = (src1_reg_q != '0) & fwd_mem_wen & (fwd_mem_dest == src1_reg_q);
    wb_hit1  = (src1_reg_q != '0) & fwd_wb_wen  & (fwd_wb_dest  == src1_reg_q);
    mem_hit2 = (src2_reg_q != '0) & fwd_mem_wen & (fwd_mem_dest == src2_reg_q);
    wb_hit2  = (src2_reg_q != '0) & fwd_wb_wen  & (fwd_wb_dest  == src2_reg_q);
    src1_byp = src1_q;
    src2_byp = src2_q;
    if (mem_hit1)     src1_byp = fwd_mem_data;
    else if (wb_hit1) src1_byp = fwd_wb_data;
    if (mem_hit2)     src2_byp = fwd_mem_data;
    else if (wb_hit2) src2_byp = fwd_wb_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      src1_reg_q <= '0;
      src2_reg_q <= '0;
      dest_q     <= '0;
      wen_q      <= 1'b0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (mem_allow) valid_q <= 1'b0;

      if (load) begin
        op_q       <= id_alu_control;
        src1_q     <= id_src1;
        src2_q     <= id_src2;
        src1_reg_q <= id_src1_reg;
        src2_reg_q <= id_src2_reg;
        dest_q     <= id_dest;
        wen_q      <= id_wen;
      end else begin
        // Sticky bypass: a forwarded value outlives its producer during a stall.
        src1_q <= src1_byp;
        src2_q <= src2_byp;
      end
    end
  end

  assign exe_valid       = valid_q;
  assign exe_alu_control = op_q;
  assign exe_alu_src1    = src1_byp;
  assign exe_alu_src2    = src2_byp;
  assign exe_result      = alu_result;
  assign exe_dest        = dest_q;
  assign exe_wen         = valid_q & wen_q & (dest_q != '0);

`ifdef EXE_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load)                   perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (valid_q & ~mem_allow)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_issue_stage.sv
// Bench for exe_issue_stage: directed scenarios then random traffic against a
// transaction-level model of the held instruction and bypass rules.
module tb_exe_issue_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush, id_valid, id_ready, id_wen, mem_allow;
  logic [4:0]    id_alu_control, exe_alu_control;
  logic [DW-1:0] id_src1, id_src2, exe_alu_src1, exe_alu_src2, alu_result, exe_result;
  logic [RW-1:0] id_src1_reg, id_src2_reg, id_dest, exe_dest;
  logic          exe_valid, exe_wen;
  logic          fwd_mem_wen, fwd_wb_wen;
  logic [RW-1:0] fwd_mem_dest, fwd_wb_dest;
  logic [DW-1:0] fwd_mem_data, fwd_wb_data;
`ifdef EXE_PERF_CNT_EN
  logic [31:0]   perf_issue_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Stand-in ALU: opcode 12 adds, nop returns 0, anything else mixes operands.
  function automatic logic [DW-1:0] ref_alu(input logic [4:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    if (op == 5'd0) return '0;
    if (op == 5'd12) return a + b;
    return a - b + DW'(op);
  endfunction

  assign alu_result = ref_alu(exe_alu_control, exe_alu_src1, exe_alu_src2);

  exe_issue_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_control(id_alu_control),
    .id_src1(id_src1), .id_src2(id_src2), .id_src1_reg(id_src1_reg),
    .id_src2_reg(id_src2_reg), .id_dest(id_dest), .id_wen(id_wen),
    .mem_allow(mem_allow), .exe_valid(exe_valid), .exe_alu_control(exe_alu_control),
    .exe_alu_src1(exe_alu_src1), .exe_alu_src2(exe_alu_src2), .alu_result(alu_result),
    .exe_result(exe_result), .exe_dest(exe_dest), .exe_wen(exe_wen),
    .fwd_mem_wen(fwd_mem_wen), .fwd_mem_dest(fwd_mem_dest), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_wen(fwd_wb_wen), .fwd_wb_dest(fwd_wb_dest), .fwd_wb_data(fwd_wb_data)
`ifdef EXE_PERF_CNT_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: one instruction slot plus counters
  typedef struct {
    logic          valid;
    logic [4:0]    op;
    logic [DW-1:0] s1, s2;
    logic [RW-1:0] r1, r2, dest;
    logic          wen;
  } slot_t;
  slot_t m;
  logic [31:0] m_issue, m_stall;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] operand(input logic [RW-1:0] r, input logic [DW-1:0] v);
    if (r == 0) return v;
    if (fwd_mem_wen && fwd_mem_dest == r) return fwd_mem_data;
    if (fwd_wb_wen && fwd_wb_dest == r) return fwd_wb_data;
    return v;
  endfunction

  task automatic model_reset();
    m = '{valid: 1'b0, op: '0, s1: '0, s2: '0, r1: '0, r2: '0, dest: '0, wen: 1'b0};
    m_issue = 0;
    m_stall = 0;
    exp_q.delete();
  endtask

  task automatic check_all();
    logic [DW-1:0] a, b;
    a = operand(m.r1, m.s1);
    b = operand(m.r2, m.s2);
    check_eq("id_ready", id_ready, !m.valid || mem_allow);
    check_eq("exe_valid", exe_valid, m.valid);
    check_eq("alu_control", exe_alu_control, m.op);
    check_eq("alu_src1", exe_alu_src1, a);
    check_eq("alu_src2", exe_alu_src2, b);
    check_eq("exe_result", exe_result, ref_alu(m.op, a, b));
    check_eq("exe_dest", exe_dest, m.dest);
    check_eq("exe_wen", exe_wen, m.valid && m.wen && m.dest != 0);
`ifdef EXE_PERF_CNT_EN
    check_eq("perf_issue", perf_issue_cnt, m_issue);
    check_eq("perf_stall", perf_stall_cnt, m_stall);
`endif
    if (exe_valid && mem_allow && !flush) begin
      if (exp_q.size() == 0) check_eq("retire_unexpected", 1, 0);
      else check_eq("retire_result", exe_result, exp_q.pop_front());
    end
  endtask

  // One cycle: check at negedge, advance the model, resume just after posedge.
  task automatic step();
    logic acc;
    @(negedge clk);
    if (m.valid && mem_allow && !flush)
      exp_q.push_back(ref_alu(m.op, operand(m.r1, m.s1), operand(m.r2, m.s2)));
    check_all();
    acc = id_valid && (!m.valid || mem_allow);
    if (m.valid && !mem_allow) m_stall++;
    if (acc && !flush) begin
      m_issue++;
      m = '{valid: 1'b1, op: id_alu_control, s1: id_src1, s2: id_src2,
            r1: id_src1_reg, r2: id_src2_reg, dest: id_dest, wen: id_wen};
    end else begin
      m.s1 = operand(m.r1, m.s1);
      m.s2 = operand(m.r2, m.s2);
      if (flush || (m.valid && mem_allow)) m.valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    flush = 0; id_valid = 0; id_alu_control = 0; id_src1 = 0; id_src2 = 0;
    id_src1_reg = 0; id_src2_reg = 0; id_dest = 0; id_wen = 0; mem_allow = 1;
    fwd_mem_wen = 0; fwd_mem_dest = 0; fwd_mem_data = 0;
    fwd_wb_wen = 0; fwd_wb_dest = 0; fwd_wb_data = 0;
  endtask

  task automatic drive_instr(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                             input logic [RW-1:0] d, input logic w);
    id_valid = 1; id_alu_control = op; id_src1 = a; id_src2 = b;
    id_src1_reg = r1; id_src2_reg = r2; id_dest = d; id_wen = w;
  endtask

  task automatic drive_random();
    flush = ($urandom_range(0, 15) == 0);
    id_valid = 1'($urandom_range(0, 1));
    id_alu_control = 5'($urandom_range(0, 18));
    id_src1 = $urandom; id_src2 = $urandom;
    id_src1_reg = RW'($urandom_range(0, 3)); id_src2_reg = RW'($urandom_range(0, 3));
    id_dest = RW'($urandom_range(0, 3)); id_wen = 1'($urandom_range(0, 1));
    mem_allow = ($urandom_range(0, 3) != 0);
    fwd_mem_wen = 1'($urandom_range(0, 1)); fwd_mem_dest = RW'($urandom_range(0, 3));
    fwd_mem_data = $urandom;
    fwd_wb_wen = 1'($urandom_range(0, 1)); fwd_wb_dest = RW'($urandom_range(0, 3));
    fwd_wb_data = $urandom;
  endtask

  initial begin
    logic [31:0] issue_before;
    // Reset
    drive_idle();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    step();

    // Basic issue
    drive_instr(5'd12, 32'd5, 32'd7, 0, 0, 5'd3, 1'b1);
    step();
    id_valid = 0; mem_allow = 0;
    #1;
    check_eq("basic_valid", exe_valid, 1);
    check_eq("basic_op", exe_alu_control, 12);
    check_eq("basic_src1", exe_alu_src1, 5);
    check_eq("basic_src2", exe_alu_src2, 7);
    check_eq("basic_result", exe_result, 12);
    check_eq("basic_wen", exe_wen, 1);
    check_eq("basic_dest", exe_dest, 3);

    // Backpressure: three stalled cycles
    repeat (3) step();
    check_eq("stall_ready", id_ready, 0);
    check_eq("stall_result", exe_result, 12);
`ifdef EXE_PERF_CNT_EN
    check_eq("stall_cnt3", perf_stall_cnt, 3);
`endif
    mem_allow = 1;
    #1 check_eq("release_ready", id_ready, 1);

    // Bypass priority and stickiness
    drive_instr(5'd12, 32'h1111, 32'd1, 5'd4, 0, 5'd6, 1'b1);
    step();
    id_valid = 0; mem_allow = 0;
    fwd_mem_wen = 1; fwd_mem_dest = 4; fwd_mem_data = 32'hAAAA;
    fwd_wb_wen = 1;  fwd_wb_dest = 4;  fwd_wb_data = 32'h5555;
    #1 check_eq("byp_mem_prio", exe_alu_src1, 32'hAAAA);
    step();
    fwd_mem_wen = 0; fwd_wb_wen = 0;
    #1 check_eq("byp_sticky", exe_alu_src1, 32'hAAAA);
    step();
    mem_allow = 1;
    drive_instr(5'd3, 32'h77, 32'd2, 0, 0, 5'd1, 1'b1);
    step();
    id_valid = 0;
    fwd_mem_wen = 1; fwd_mem_dest = 0; fwd_mem_data = 32'hDEAD;
    fwd_wb_wen = 1;  fwd_wb_dest = 0;  fwd_wb_data = 32'hBEEF;
    #1 check_eq("byp_r0", exe_alu_src1, 32'h77);
    step();
    fwd_mem_wen = 0; fwd_wb_wen = 0;

    // Flush versus accept
    drive_instr(5'd12, 1, 2, 0, 0, 5'd2, 1'b1);
    step();
    issue_before = m_issue;
    drive_instr(5'd5, 3, 4, 0, 0, 5'd7, 1'b1);
    flush = 1;
    step();
    flush = 0; id_valid = 0;
    #1 check_eq("flush_valid", exe_valid, 0);
`ifdef EXE_PERF_CNT_EN
    check_eq("flush_issue_cnt", perf_issue_cnt, issue_before);
`endif

    // Destination zero never writes
    drive_instr(5'd12, 9, 9, 0, 0, 5'd0, 1'b1);
    step();
    id_valid = 0;
    #1;
    check_eq("dest0_valid", exe_valid, 1);
    check_eq("dest0_wen", exe_wen, 0);

    // Asynchronous reset in the middle of a stall
    mem_allow = 0;
    step();
    #1 resetn = 0;
    #1;
    check_eq("areset_valid", exe_valid, 0);
    check_eq("areset_op", exe_alu_control, 0);
    model_reset();
    #1 resetn = 1;
    step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
    end
    drive_idle();
    repeat (3) step();
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_issue_stage.md
Name: exe_issue_stage

Overview:
- ID/EXE pipeline stage that sits directly upstream of the 5-bit-opcode combinational ALU.
- Latches one decoded instruction from ID and drives the ALU control and operand inputs.
- Resolves register operands through a MEM/WB bypass network.
- Hands the ALU result, destination and write enable to MEM with a valid/allow handshake.

Parameters:
- DW, 32, datapath width (ALU operands and result)
- RW, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction held in EXE
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  EXE can accept this cycle
- id_alu_control  in  5  ALU opcode (1..18; 0 = nop)
- id_src1  in  DW  operand 1 value read in ID
- id_src2  in  DW  operand 2 value read in ID
- id_src1_reg  in  RW  operand 1 source register (0 = immediate/none)
- id_src2_reg  in  RW  operand 2 source register (0 = immediate/none)
- id_dest  in  RW  destination register
- id_wen  in  1  instruction writes a register
- mem_allow  in  1  MEM accepts this cycle
- exe_valid  out  1  EXE holds a live instruction
- exe_alu_control  out  5  to ALU opcode input
- exe_alu_src1  out  DW  to ALU operand 1 (bypassed)
- exe_alu_src2  out  DW  to ALU operand 2 (bypassed)
- alu_result  in  DW  from ALU, combinational
- exe_result  out  DW  result to MEM
- exe_dest  out  RW  destination to MEM
- exe_wen  out  1  qualified write enable to MEM
- fwd_mem_wen  in  1  MEM-stage write pending
- fwd_mem_dest  in  RW  MEM-stage destination
- fwd_mem_data  in  DW  MEM-stage result
- fwd_wb_wen  in  1  WB-stage write pending
- fwd_wb_dest  in  RW  WB-stage destination
- fwd_wb_data  in  DW  WB-stage result

Behaviour:
- Reset (async, resetn=0): exe_valid=0; stored opcode, operands, src regs, dest and wen = 0. The ALU therefore sees opcode 0 and returns 0.
- id_ready = !exe_valid | mem_allow. It is combinational and independent of id_valid.
- Accept on id_valid & id_ready: next cycle exe_valid=1 and all id_* fields are latched. Latency ID→ALU is 1 cycle.
- Drain without refill: exe_valid & mem_allow & !id_valid clears exe_valid next cycle.
- Stall: exe_valid & !mem_allow holds every stored field. Outputs stay stable except for bypass updates.
- flush: exe_valid=0 next cycle. Flush has priority over a simultaneous accept, and the ID instruction is dropped. id_ready is not gated by flush.
- Bypass, evaluated per operand every cycle on the stored src reg r:
  - r=0: never bypassed.
  - MEM hit (fwd_mem_wen & fwd_mem_dest==r) has priority over WB hit (fwd_wb_wen & fwd_wb_dest==r).
  - On a hit, exe_alu_srcN shows the forwarded data combinationally in the same cycle, and the stored operand is overwritten with it at the clock edge (sticky). The value therefore survives the producer retiring during a stall.
  - With no hit, the stored value is used.
- Bypass is applied only in EXE. Values already on id_src* at accept time are taken as-is.
- exe_result = alu_result (combinational). exe_dest = stored dest. exe_wen = exe_valid & stored wen & (stored dest != 0).
- exe_alu_control = stored opcode whether exe_valid is 0 or 1. MEM must qualify by exe_valid.
- Widths: no arithmetic in this block. All fields pass through unmodified at their declared width.

Optional Feature:
- Macro EXE_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_issue_cnt [31:0]: +1 per accepted, non-flushed instruction.
  - perf_stall_cnt [31:0]: +1 per cycle with exe_valid & !mem_allow.
- Both counters reset to 0 on resetn, wrap 0xFFFFFFFF→0, and are unaffected by flush except that a flushed accept is not counted.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Basic issue: reset, then id_valid=1, opcode=12, src1=5, src2=7, regs=0, dest=3, wen=1, mem_allow=1 → next cycle exe_valid=1, ALU sees (12,5,7), exe_result=12, exe_wen=1, exe_dest=3.
- Backpressure: stage held, mem_allow=0 for 3 cycles → id_ready=0, outputs frozen; with EXE_PERF_CNT_EN, perf_stall_cnt=3. mem_allow=1 → id_ready=1 the same cycle.
- Bypass priority and stickiness:
  - src1_reg=4, MEM writes r4=0xAAAA and WB writes r4=0x5555 in the same cycle → exe_alu_src1=0xAAAA.
  - Keep stalled and drop fwd_mem_wen next cycle → src1 stays 0xAAAA.
  - src1_reg=0 with fwd dest=0 → no bypass.
- Flush versus accept: exe_valid=1, mem_allow=1, id_valid=1, flush=1 → next cycle exe_valid=0; perf_issue_cnt does not increment.
- Dest zero: dest=0, wen=1 → exe_wen=0 while exe_valid=1.
- Async reset mid-stall: resetn low between clock edges → exe_valid=0 and exe_alu_control=0 immediately, without waiting for a clock edge.
